// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a doubleword memory port.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemTypeM,
  input  logic [63:0] ALUResultM,
  input  logic [63:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        StallM,
  output logic [63:0] ReadDataM,
  output logic        BusErrM,
  output logic        MisalignM
);

  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW > 8) ? CW_RAW : 8;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    offset_raw, offset;
  logic          access_req, trap, start, timeout;
  logic [7:0]    strb_calc;
  logic [63:0]   wdata_calc;
  logic          we_q;
  logic [1:0]    type_q;
  logic [2:0]    off_q;
  logic [63:0]   rdata_shift, load_data;

  assign offset_raw = ALUResultM[2:0];
  assign access_req = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (MemTypeM)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = offset_raw[0];
      2'b10:   misaligned = |offset_raw[1:0];
      default: misaligned = |offset_raw;
    endcase
  end

  assign offset = offset_raw;
  assign trap   = access_req & misaligned;
`else
  // Low offset bits dropped so every access lands on its natural boundary.
  always_comb begin
    offset = offset_raw;
    case (MemTypeM)
      2'b00:   offset = offset_raw;
      2'b01:   offset = {offset_raw[2:1], 1'b0};
      2'b10:   offset = {offset_raw[2], 2'b00};
      default: offset = 3'b000;
    endcase
  end

  assign trap = 1'b0;
`endif

  always_comb begin
    strb_calc = 8'h00;
    case (MemTypeM)
      2'b00:   strb_calc = 8'h01 << offset;
      2'b01:   strb_calc = 8'h03 << offset;
      2'b10:   strb_calc = 8'h0F << offset;
      default: strb_calc = 8'hFF;
    endcase
  end

  assign wdata_calc = WriteDataM << {offset, 3'b000};

  assign start   = (state == IDLE) & access_req & ~trap;
  // Ack has priority over an expiring counter in the same cycle.
  assign timeout = (state == BUSY) & ~mem_ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (access_req) state_next = trap ? DONE : BUSY;
      end
      BUSY: begin
        if (mem_ack || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    StallM  = 1'b0;
    case (state)
      BUSY: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        StallM  = 1'b1;
      end
      IDLE:    StallM = access_req;
      default: ;
    endcase
  end

  assign rdata_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rdata_shift;
    case (type_q)
      2'b00:   load_data = {{56{rdata_shift[7]}},  rdata_shift[7:0]};
      2'b01:   load_data = {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      2'b10:   load_data = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      default: load_data = rdata_shift;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      we_q      <= 1'b0;
      type_q    <= '0;
      off_q     <= '0;
      wait_cnt  <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      BusErrM <= timeout;
      if (start) begin
        mem_addr  <= {ALUResultM[63:3], 3'b000};
        mem_wdata <= wdata_calc;
        mem_wstrb <= MemWriteM ? strb_calc : 8'h00;
        we_q      <= MemWriteM;
        type_q    <= MemTypeM;
        off_q     <= offset;
        wait_cnt  <= '0;
      end
      if (state == BUSY && !mem_ack) wait_cnt <= wait_cnt + 1'b1;
      if (timeout || (state == IDLE && trap)) ReadDataM <= '0;
      else if (state == BUSY && mem_ack && !we_q) ReadDataM <= load_data;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) MisalignM <= 1'b0;
    else       MisalignM <= (state == IDLE) & trap;
  end
`else
  assign MisalignM = 1'b0;
`endif

endmodule
